md5_stream: RTL and testbench

- Multi-block, streaming successor to the single-block md5 core.
- Accepts a message of any length as a sequence of 512-bit blocks over a valid/ready handshake and performs MD5 padding internally, inserting an extra pad block when needed.
- Runs 64 rounds per block at a parametrised number of rounds per cycle, then presents the 128-bit digest on a held valid/ack output.

---
 rtl/md5_pkg.sv | 77 +++++++
 rtl/md5_round.sv | 30 +++
 rtl/md5_stream.sv | 178 +++++++++++++++++
 tb/tb_md5_stream.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md5_pkg.sv
// rtl/md5_pkg.sv - MD5 round constants, IV, FSM state type and per-round helpers
package md5_pkg;

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;

  localparam logic [31:0] K_TAB [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  typedef enum logic [2:0] {IDLE, ROUND, ADD, PAD, DONE} state_t;

  // Shift amount repeats every four rounds within each group of sixteen.
  function automatic logic [4:0] shift_amt(input logic [5:0] idx);
    logic [4:0] s;
    case ({idx[5:4], idx[1:0]})
      4'h0: s = 5'd7;   4'h1: s = 5'd12;  4'h2: s = 5'd17;  4'h3: s = 5'd22;
      4'h4: s = 5'd5;   4'h5: s = 5'd9;   4'h6: s = 5'd14;  4'h7: s = 5'd20;
      4'h8: s = 5'd4;   4'h9: s = 5'd11;  4'ha: s = 5'd16;  4'hb: s = 5'd23;
      4'hc: s = 5'd6;   4'hd: s = 5'd10;  4'he: s = 5'd15;  default: s = 5'd21;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] round_f(input logic [5:0] idx, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] d);
    logic [31:0] f;
    case (idx[5:4])
      2'd0:    f = (b & c) | (~b & d);
      2'd1:    f = (d & b) | (~d & c);
      2'd2:    f = b ^ c ^ d;
      default: f = c ^ (b | ~d);
    endcase
    return f;
  endfunction

  function automatic logic [3:0] msg_idx(input logic [5:0] idx);
    logic [3:0] i;
    logic [3:0] g;
    i = idx[3:0];
    case (idx[5:4])
      2'd0:    g = i;
      2'd1:    g = i * 4'd5 + 4'd1;
      2'd2:    g = i * 4'd3 + 4'd5;
      default: g = i * 4'd7;
    endcase
    return g;
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  function automatic logic [63:0] bswap64(input logic [63:0] v);
    logic [63:0] r;
    for (int j = 0; j < 8; j++) r[8*(7-j) +: 8] = v[8*j +: 8];
    return r;
  endfunction

endpackage

// File: rtl/md5_round.sv
// rtl/md5_round.sv - one combinational MD5 step; chained inside md5_stream
module md5_round
  import md5_pkg::*;
(
  input  logic [5:0]  i_idx,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_c,
  input  logic [31:0] i_d,
  input  logic [31:0] i_m,
  output logic [31:0] o_a,
  output logic [31:0] o_b,
  output logic [31:0] o_c,
  output logic [31:0] o_d
);

  logic [31:0] w_sum;
  logic [4:0]  w_s;
  logic [31:0] w_rot;

  assign w_sum = i_a + round_f(i_idx, i_b, i_c, i_d) + K_TAB[i_idx] + i_m;
  assign w_s   = shift_amt(i_idx);
  assign w_rot = (w_sum << w_s) | (w_sum >> (6'd32 - {1'b0, w_s}));

  assign o_a = i_d;
  assign o_b = i_b + w_rot;
  assign o_c = i_b;
  assign o_d = i_c;

endmodule

// File: rtl/md5_stream.sv
// rtl/md5_stream.sv - streaming multi-block MD5 with internal padding.
// Defining MD5_PROTOCOL_CHECK_EN adds a sticky err output for in_bytes > 64.
module md5_stream
  import md5_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int LEN_W            = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_data,
  input  logic         in_last,
  input  logic [6:0]   in_bytes,
  output logic [127:0] hash,
  output logic         hash_valid,
`ifdef MD5_PROTOCOL_CHECK_EN
  output logic         err,
`endif
  input  logic         hash_ack
);

  localparam logic [5:0] LAST_IDX = 6'(64 - ROUNDS_PER_CYCLE);
  localparam logic [5:0] R_INC    = 6'(ROUNDS_PER_CYCLE);

  state_t           r_state, w_next;
  logic             r_ready, r_hash_valid, r_last, r_pad_pending, r_pad80;
  logic [127:0]     r_hash;
  logic [511:0]     r_blk;
  logic [5:0]       r_round;
  logic [LEN_W-1:0] r_len;
  logic [31:0]      r_h0, r_h1, r_h2, r_h3, r_a, r_b, r_c, r_d;

  logic             w_accept;
  logic [6:0]       w_n;
  logic [LEN_W-1:0] w_len_new;
  logic [511:0]     w_in_blk, w_pad_blk;
  logic [31:0]      w_m [16];
  logic [31:0]      w_sa, w_sb, w_sc, w_sd, w_ra, w_rb, w_rc, w_rd;

  assign w_accept = in_valid & r_ready;

  // Input block with bytes past n masked, 0x80 inserted and length placed when it fits.
  always_comb begin
`ifdef MD5_PROTOCOL_CHECK_EN
    w_n = (!in_last || in_bytes > 7'd64) ? 7'd64 : in_bytes;
`else
    w_n = in_last ? in_bytes : 7'd64;
`endif
    w_len_new = r_len + (in_last ? LEN_W'({w_n, 3'b000}) : LEN_W'(512));
    w_in_blk  = '0;
    for (int k = 0; k < 64; k++) begin
      if (7'(k) < w_n)       w_in_blk[8*(63-k) +: 8] = in_data[8*(63-k) +: 8];
      else if (7'(k) == w_n) w_in_blk[8*(63-k) +: 8] = 8'h80;
    end
    if (in_last && w_n <= 7'd55) w_in_blk[63:0] = bswap64(64'(w_len_new));
  end

  assign w_pad_blk = {(r_pad80 ? 8'h80 : 8'h00), 440'd0, bswap64(64'(r_len))};

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      w_m[i] = {r_blk[8*(60-4*i) +: 8], r_blk[8*(61-4*i) +: 8],
                r_blk[8*(62-4*i) +: 8], r_blk[8*(63-4*i) +: 8]};
    end
  end

  for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_round
    logic [5:0]  w_idx;
    logic [31:0] w_ia, w_ib, w_ic, w_id, w_oa, w_ob, w_oc, w_od, w_mw;
    assign w_idx = r_round + 6'(j);
    assign w_mw  = w_m[msg_idx(w_idx)];
    if (j == 0) begin : g_first
      assign {w_ia, w_ib, w_ic, w_id} = {r_a, r_b, r_c, r_d};
    end else begin : g_next
      assign {w_ia, w_ib, w_ic, w_id} =
        {g_round[j-1].w_oa, g_round[j-1].w_ob, g_round[j-1].w_oc, g_round[j-1].w_od};
    end
    md5_round u_round (
      .i_idx(w_idx), .i_a(w_ia), .i_b(w_ib), .i_c(w_ic), .i_d(w_id), .i_m(w_mw),
      .o_a(w_oa), .o_b(w_ob), .o_c(w_oc), .o_d(w_od)
    );
  end

  assign w_ra = g_round[ROUNDS_PER_CYCLE-1].w_oa;
  assign w_rb = g_round[ROUNDS_PER_CYCLE-1].w_ob;
  assign w_rc = g_round[ROUNDS_PER_CYCLE-1].w_oc;
  assign w_rd = g_round[ROUNDS_PER_CYCLE-1].w_od;

  assign w_sa = r_h0 + r_a;
  assign w_sb = r_h1 + r_b;
  assign w_sc = r_h2 + r_c;
  assign w_sd = r_h3 + r_d;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = ROUND;
      ROUND:   if (r_round == LAST_IDX) w_next = ADD;
      ADD:     w_next = r_pad_pending ? PAD : (r_last ? DONE : IDLE);
      PAD:     w_next = ROUND;
      DONE:    if (hash_ack) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ready       <= 1'b0;
      r_hash_valid  <= 1'b0;
      r_hash        <= '0;
      r_len         <= '0;
      r_blk         <= '0;
      r_round       <= '0;
      r_last        <= 1'b0;
      r_pad_pending <= 1'b0;
      r_pad80       <= 1'b0;
      {r_h0, r_h1, r_h2, r_h3} <= {IV_A, IV_B, IV_C, IV_D};
      {r_a, r_b, r_c, r_d}     <= '0;
    end else begin
      r_ready <= (w_next == IDLE);
      case (r_state)
        IDLE: if (w_accept) begin
          r_blk         <= w_in_blk;
          r_len         <= w_len_new;
          r_round       <= '0;
          r_last        <= in_last;
          r_pad_pending <= in_last && (w_n >= 7'd56);
          r_pad80       <= in_last && (w_n == 7'd64);
          {r_a, r_b, r_c, r_d} <= {r_h0, r_h1, r_h2, r_h3};
        end
        ROUND: begin
          {r_a, r_b, r_c, r_d} <= {w_ra, w_rb, w_rc, w_rd};
          r_round <= r_round + R_INC;
        end
        ADD: begin
          {r_h0, r_h1, r_h2, r_h3} <= {w_sa, w_sb, w_sc, w_sd};
          if (!r_pad_pending && r_last) begin
            r_hash       <= {bswap32(w_sa), bswap32(w_sb), bswap32(w_sc), bswap32(w_sd)};
            r_hash_valid <= 1'b1;
          end
        end
        PAD: begin
          r_blk         <= w_pad_blk;
          r_round       <= '0;
          r_pad_pending <= 1'b0;
          {r_a, r_b, r_c, r_d} <= {r_h0, r_h1, r_h2, r_h3};
        end
        DONE: if (hash_ack) begin
          r_hash_valid <= 1'b0;
          r_len        <= '0;
          {r_h0, r_h1, r_h2, r_h3} <= {IV_A, IV_B, IV_C, IV_D};
        end
        default: ;
      endcase
    end
  end

`ifdef MD5_PROTOCOL_CHECK_EN
  logic r_err;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                  r_err <= 1'b0;
    else if (w_accept && in_last && in_bytes > 7'd64) r_err <= 1'b1;
  end
  assign err = r_err;
`endif

  assign in_ready   = r_ready;
  assign hash_valid = r_hash_valid;
  assign hash       = r_hash;

endmodule

// File: tb/tb_md5_stream.sv
// tb/tb_md5_stream.sv - scoreboard bench for md5_stream (known-answer digests, timing, backpressure)
module tb_md5_stream;

  localparam int R  = 4;
  localparam int L1 = 64 / R + 1;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_data;
  logic         in_last;
  logic [6:0]   in_bytes;
  logic [127:0] hash;
  logic         hash_valid;
  logic         hash_ack;
`ifdef MD5_PROTOCOL_CHECK_EN
  logic         err;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  logic [127:0] sb_q [$];

  md5_stream #(.ROUNDS_PER_CYCLE(R), .LEN_W(64)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .in_bytes(in_bytes),
    .hash(hash), .hash_valid(hash_valid),
`ifdef MD5_PROTOCOL_CHECK_EN
    .err(err),
`endif
    .hash_ack(hash_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic drive_block(input logic [511:0] blk, input logic last, input logic [6:0] nb);
    int w;
    @(negedge clk);
    in_data = blk; in_last = last; in_bytes = nb; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL ready_wait: in_ready=%b required 1 within 200 cycles", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_msg(input string msg, input logic [127:0] exp, output int lat);
    int len, nblk, nb;
    logic [511:0] blk;
    len  = msg.len();
    nblk = (len == 0) ? 1 : (len + 63) / 64;
    nb   = 0;
    for (int b = 0; b < nblk; b++) begin
      nb = (b == nblk - 1) ? len - 64 * b : 64;
      for (int k = 0; k < 64; k++) blk[8*(63-k) +: 8] = 8'($urandom);
      for (int k = 0; k < nb; k++) blk[8*(63-k) +: 8] = msg[64*b + k];
      if (b == nblk - 1) sb_q.push_back(exp);
      drive_block(blk, b == nblk - 1, 7'(nb));
    end
    lat = (nb >= 56) ? 2 * L1 + 1 : L1;
  endtask

  task automatic collect(input string name, input int lat_exp, input int hold);
    int n;
    bit seen_ready;
    logic [127:0] exp;
    n = 0; seen_ready = 0;
    forever begin
      @(negedge clk);
      if (hash_valid === 1'b1 || n >= 1000) break;
      if (in_ready) seen_ready = 1;
      @(posedge clk);
      n++;
    end
    tests_run++;
    if (hash_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s timeout: hash_valid=%b required 1", name, hash_valid);
    end
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 128'hx;
    tests_run++;
    if (hash !== exp) begin
      tests_failed++;
      $display("FAIL %s digest: got %h required %h", name, hash, exp);
    end
    tests_run++;
    if (n != lat_exp) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d edges required %0d", name, n, lat_exp);
    end
    tests_run++;
    if (seen_ready || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s busy_ready: in_ready seen high=%0d now=%b required 0", name, seen_ready, in_ready);
    end
    if (hold > 0) begin
      in_valid = 1'b1; in_last = 1'b1; in_bytes = 7'd3;
      in_data = {$urandom, $urandom, 448'd0};
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (hash !== exp || hash_valid !== 1'b1 || in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s hold[%0d]: hash=%h valid=%b ready=%b required %h 1 0",
                 name, i, hash, hash_valid, in_ready, exp);
      end
    end
    in_valid = 1'b0;
    hash_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    hash_ack = 1'b0;
    tests_run++;
    if (hash_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s ack: valid=%b ready=%b required 0 1", name, hash_valid, in_ready);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_bytes = '0;
    in_data = '0; hash_ack = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b0 || hash_valid !== 1'b0 || hash !== 128'd0) begin
      tests_failed++;
      $display("FAIL reset_values: ready=%b valid=%b hash=%h required 0 0 0", in_ready, hash_valid, hash);
    end
`ifdef MD5_PROTOCOL_CHECK_EN
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_err: err=%b required 0", err);
    end
`endif
    reset_n = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release_ready: in_ready=%b required 0 before first edge", in_ready);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_first_edge_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_empty;
    int lat;
    run_msg("", 128'hd41d8cd98f00b204e9800998ecf8427e, lat);
    collect("empty", lat, 0);
  endtask

  task automatic test_abc_timing;
    int lat;
    run_msg("abc", 128'h900150983cd24fb0d6963f7d28e17f72, lat);
    collect("abc", lat, 0);
  endtask

  task automatic test_fox_hold;
    int lat;
    run_msg("The quick brown fox jumps over the lazy dog",
            128'h9e107d9d372bb6826bd81d3542a419d6, lat);
    collect("fox", lat, 10);
  endtask

  task automatic test_multiblock;
    int lat;
    string s;
    s = "";
    for (int i = 0; i < 8; i++) s = {s, "1234567890"};
    run_msg(s, 128'h57edf4a22be3c955ac49da2e2107b67a, lat);
    collect("digits80", lat, 0);
  endtask

  task automatic test_pad_block;
    int lat;
    run_msg("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq",
            128'h8215ef0796a20bcaaae116d3876c664a, lat);
    collect("pad56", lat, 0);
    run_msg("ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789",
            128'hd174ab98d277d9f5a5611c2c9f419d9f, lat);
    collect("pad62", lat, 0);
  endtask

  task automatic test_reset_mid_round;
    int lat;
    logic [511:0] blk;
    string s;
    s = "1234567890123456789012345678901234567890123456789012345678901234";
    for (int k = 0; k < 64; k++) blk[8*(63-k) +: 8] = s[k];
    drive_block(blk, 1'b0, 7'd64);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b0 || hash_valid !== 1'b0 || hash !== 128'd0) begin
      tests_failed++;
      $display("FAIL midreset_values: ready=%b valid=%b hash=%h required 0 0 0", in_ready, hash_valid, hash);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_ready: in_ready=%b required 1", in_ready);
    end
    run_msg("abc", 128'h900150983cd24fb0d6963f7d28e17f72, lat);
    collect("abc_after_reset", lat, 0);
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clk);
    hash_ack = 1'b1;
    @(negedge clk);
    hash_ack = 1'b0;
    tests_run++;
    if (hash_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL idle_ack: valid=%b ready=%b required 0 1", hash_valid, in_ready);
    end
    run_msg("a", 128'h0cc175b9c0f1b6a831c399e269772661, lat);
    collect("a", lat, 0);
    run_msg("message digest", 128'hf96b697d7cb7938d525a2f31aaf161d0, lat);
    collect("message_digest", lat, 0);
    run_msg("abcdefghijklmnopqrstuvwxyz", 128'hc3fcd3d76192e4007dfb496cca67e13b, lat);
    collect("alphabet", lat, 0);
  endtask

`ifdef MD5_PROTOCOL_CHECK_EN
  task automatic test_protocol_err;
    int n;
    drive_block({16{32'h5a5a1234}}, 1'b1, 7'd70);
    tests_run++;
    if (err !== 1'b1) begin
      tests_failed++;
      $display("FAIL proto_err: err=%b required 1", err);
    end
    n = 0;
    while (hash_valid !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (hash_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL proto_done: hash_valid=%b required 1", hash_valid);
    end
    hash_ack = 1'b1;
    @(negedge clk);
    hash_ack = 1'b0;
    tests_run++;
    if (err !== 1'b1) begin
      tests_failed++;
      $display("FAIL proto_sticky: err=%b required 1", err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_empty();
    test_abc_timing();
    test_fox_hold();
    test_multiblock();
    test_pad_block();
    test_reset_mid_round();
    test_back_to_back();
`ifdef MD5_PROTOCOL_CHECK_EN
    test_protocol_err();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
